dm_port_arbiter: RTL and testbench

// - Shares the single data-memory/bridge port between two masters: M0 = CPU M-stage load/store, M1 = DMA/debug engine.
// - Masters present a store already packed by the byte-enable unit: word address, byteen[3:0], lane-aligned wdata.
// - Round-robin arbitration, one outstanding transaction, variable-latency slave with ack and a timeout watchdog.

---
 rtl/dm_port_arbiter.sv | 119 +++++++++++
 tb/tb_dm_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin share of the data-memory/bridge port between CPU (M0) and DMA (M1).
// Define MISALIGN_CHECK_EN to reject illegal byte-enable patterns at grant instead of forwarding them.
module dm_port_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        slv_req,
  output logic        slv_we,
  output logic [31:0] slv_addr,
  output logic [3:0]  slv_byteen,
  output logic [31:0] slv_wdata,
  input  logic        slv_ack,
  input  logic [31:0] slv_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYC - 1);
  state_t      state;
  logic        last_grant, gnt, err_q;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        r0, r1, any, pick, ok;
  logic [3:0]  sel_byteen;
  // a master whose ack is on the wire this cycle is still holding req for the finished access
  always_comb begin
    r0 = m0_req & ~m0_ack;
    r1 = m1_req & ~m1_ack;
    any = r0 | r1;
    pick = r1 & (~r0 | ~last_grant);
    sel_byteen = pick ? m1_byteen : m0_byteen;
  end
`ifdef MISALIGN_CHECK_EN
  assign ok = sel_byteen inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
`else
  assign ok = 1'b1;
`endif
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      rdata_q <= '0;
      slv_req <= 1'b0;
      slv_we <= 1'b0;
      slv_addr <= '0;
      slv_byteen <= '0;
      slv_wdata <= '0;
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m0_rdata <= '0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: if (any) begin
          slv_we <= pick ? m1_we : m0_we;
          slv_addr <= pick ? m1_addr : m0_addr;
          slv_byteen <= sel_byteen;
          slv_wdata <= pick ? m1_wdata : m0_wdata;
          last_grant <= pick;
          gnt <= pick;
          cnt <= '0;
          rdata_q <= '0;
          err_q <= ~ok;
          slv_req <= ok;
          state <= ok ? ISSUE : RESP;
        end
        ISSUE: begin
          cnt <= cnt + 8'd1;
          if (slv_ack) begin
            rdata_q <= slv_rdata;
            slv_req <= 1'b0;
            state <= RESP;
          end else if (cnt == CNT_MAX) begin
            slv_req <= 1'b0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          m0_ack <= ~gnt;
          m1_ack <= gnt;
          m0_err <= ~gnt & err_q;
          m1_err <= gnt & err_q;
          m0_rdata <= gnt ? m0_rdata : rdata_q;
          m1_rdata <= gnt ? rdata_q : m1_rdata;
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: randomized bench with a timeline reference model and queue-based scoreboard.
module tb_dm_port_arbiter;
  localparam int TO = 16;
`ifdef MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, slv_ack = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, slv_rdata = 0;
  logic [3:0] m0_byteen = 0, m1_byteen = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, slv_req, slv_we, busy;
  logic [31:0] m0_rdata, m1_rdata, slv_addr, slv_wdata;
  logic [3:0] slv_byteen;

  dm_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_byteen(slv_byteen),
    .slv_wdata(slv_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m; logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
    int lat; logic [31:0] rdata; int g;
  } slv_t;
  typedef struct { int m; logic err; logic [31:0] rdata; int at; } ack_t;

  slv_t slv_q[$];
  ack_t ack_q[$];
  int total = 0, bad = 0, cyc = 0;
  int free_at = 0, busy_from = 0, ack_m = -1, last = 1, lat_force = -1;
  logic [3:0] legal_be [8] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic bit be_ok(input logic [3:0] b);
    return !CHK_EN || (b inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0});
  endfunction

  // Timeline model: the port frees up on the ack cycle, lat = slave wait cycles after slv_req rises
  always @(posedge clk) begin
    bit e0, e1;
    int p, r;
    slv_t s;
    ack_t a;
    if (!reset) begin
      slv_q.delete(); ack_q.delete();
      free_at = 0; busy_from = 0; ack_m = -1; last = 1;
    end else if (cyc >= free_at) begin
      e0 = m0_req && !(cyc == free_at && ack_m == 0);
      e1 = m1_req && !(cyc == free_at && ack_m == 1);
      if (e0 || e1) begin
        p = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
        s.m = p; s.g = cyc;
        s.we = p ? m1_we : m0_we;
        s.addr = p ? m1_addr : m0_addr;
        s.be = p ? m1_byteen : m0_byteen;
        s.wdata = p ? m1_wdata : m0_wdata;
        r = $urandom_range(0, 11);
        s.lat = lat_force >= 0 ? lat_force : (r < 9 ? r % 5 : (r == 9 ? TO - 1 : (r == 10 ? TO - 2 : TO)));
        s.rdata = $urandom;
        a.m = p;
        if (!be_ok(s.be)) begin
          a.err = 1; a.rdata = 0; a.at = cyc + 2;
        end else begin
          slv_q.push_back(s);
          a.err = s.lat >= TO;
          a.rdata = s.lat >= TO ? 32'd0 : s.rdata;
          a.at = s.lat >= TO ? cyc + TO + 2 : cyc + 3 + s.lat;
        end
        ack_q.push_back(a);
        busy_from = cyc; free_at = a.at; ack_m = p; last = p;
      end
    end
    cyc++;
  end

  // Slave: acks after the model-chosen wait, junk data otherwise, stray acks while idle
  int k = 0;
  bit in_txn = 0;
  slv_t cur;
  always @(negedge clk) begin
    slv_ack = 0;
    slv_rdata = $urandom;
    if (!reset) in_txn = 0;
    else if (slv_req) begin
      if (!in_txn) begin
        if (slv_q.size() == 0) begin
          chk("slv_q_depth", slv_q.size(), 1);
          cur.lat = TO;
        end else begin
          cur = slv_q.pop_front();
          chk("slv_req_cycle", cyc, cur.g + 1);
          chk("slv_we", slv_we, cur.we);
          chk("slv_addr", slv_addr, cur.addr);
          chk("slv_byteen", slv_byteen, cur.be);
          chk("slv_wdata", slv_wdata, cur.wdata);
        end
        in_txn = 1; k = 0;
      end else k++;
      if (k == cur.lat) begin slv_ack = 1; slv_rdata = cur.rdata; end
    end else begin
      if (in_txn) begin
        chk("slv_req_len", k + 1, cur.lat < TO ? cur.lat + 1 : TO);
        in_txn = 0;
      end
      if ($urandom_range(0, 3) == 0) slv_ack = 1;
    end
  end

  always @(negedge clk) begin
    ack_t a;
    if (reset) begin
      chk("busy", busy, cyc > busy_from && cyc < free_at);
      if (m0_ack || m1_ack) begin
        chk("dual_ack", m0_ack & m1_ack, 0);
        if (ack_q.size() == 0) chk("ack_q_depth", ack_q.size(), 1);
        else begin
          a = ack_q.pop_front();
          chk("ack_master", m1_ack, a.m);
          chk("ack_cycle", cyc, a.at);
          chk("ack_err", a.m ? m1_err : m0_err, a.err);
          chk("ack_rdata", a.m ? m1_rdata : m0_rdata, a.rdata);
        end
      end else begin
        chk("err_without_ack", m0_err | m1_err, 0);
        if (ack_q.size() > 0 && cyc > ack_q[0].at) begin
          chk("ack_cycle", cyc, ack_q[0].at);
          void'(ack_q.pop_front());
        end
      end
    end
  end

  task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin m0_req = req; m0_we = we; m0_addr = addr; m0_byteen = be; m0_wdata = wd; end
    else begin m1_req = req; m1_we = we; m1_addr = addr; m1_byteen = be; m1_wdata = wd; end
  endtask

  // Called at a negedge; returns at the negedge where the ack is seen
  task automatic do_txn(input int m, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input bit keep);
    int n = 0;
    set_m(m, 1, we, addr, be, wd);
    do begin @(negedge clk); n++; end while (!(m ? m1_ack : m0_ack) && n < 200);
    if (n >= 200) chk("ack_wait", m ? m1_ack : m0_ack, 1);
    if (!keep) begin if (m == 0) m0_req = 0; else m1_req = 0; end
  endtask

  task automatic run_master(input int m, input int n, input int maxgap);
    int g;
    bit keep;
    logic [3:0] be;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, maxgap);
      keep = (g == 0) && (i < n - 1);
      be = m ? 4'($urandom) : legal_be[$urandom_range(0, 7)];
      do_txn(m, 1'($urandom), $urandom & 32'hFFFF_FFFC, be, $urandom, keep);
      if (!keep) repeat (g) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("rst_slv_req", slv_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_slv_addr", slv_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    lat_force = 0;
    fork
      do_txn(0, 1, 32'h0000_2000, 4'hF, 32'h1111_1111, 0);
      do_txn(1, 0, 32'h0000_3000, 4'hF, 32'h2222_2222, 0);
    join
    chk("both_last_addr", slv_addr, 32'h0000_3000);
    repeat (2) @(negedge clk);
    do_txn(0, 1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 0);
    chk("sw_slv_addr", slv_addr, 32'h0000_1004);
    chk("sw_slv_wdata", slv_wdata, 32'hDEAD_BEEF);
    chk("sw_slv_byteen", slv_byteen, 4'hF);
    chk("sw_slv_we", slv_we, 1);
    @(negedge clk);
    lat_force = -1;
    fork
      run_master(1, 6, 0);
      run_master(0, 6, 2);
    join
    @(negedge clk);
    lat_force = 100;
    do_txn(0, 0, 32'h0000_4000, 4'hF, 32'h0, 0);
    @(negedge clk);
    set_m(0, 1, 1, 32'h0000_5000, 4'hF, 32'h5555_5555);
    n = 0;
    do begin @(negedge clk); n++; end while (!slv_req && n < 20);
    chk("issue_reached", slv_req, 1);
    repeat (3) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("async_slv_req", slv_req, 0);
    chk("async_busy", busy, 0);
    m0_req = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    lat_force = 0;
    fork
      do_txn(0, 0, 32'h0000_6000, 4'hF, 32'h0, 0);
      do_txn(1, 0, 32'h0000_7000, 4'hF, 32'h0, 0);
    join
    chk("post_rst_last_addr", slv_addr, 32'h0000_7000);
    @(negedge clk);
    do_txn(1, 1, 32'h0000_8000, 4'b0110, 32'hA5A5_A5A5, 0);
    chk("bad_be_slv_byteen", slv_byteen, 4'b0110);
    @(negedge clk);
    lat_force = -1;
    fork
      run_master(0, 30, 3);
      run_master(1, 30, 2);
    join
    repeat (5) @(negedge clk);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("slv_q_drained", slv_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
